// File: rtl/shift_ser_pkg.sv
// Shared definitions for the framed serial-in receiver.
// Provides the bit-order constants and the counter-width helper.
package shift_ser_pkg;

    localparam bit LSB_FIRST = 1'b0;
    localparam bit MSB_FIRST = 1'b1;

    // Bit counter spans 0..width-1; keep at least one bit.
    function automatic int CNT_W(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/shift_ser_core.sv
// Shift register, bit counter and completion strobe (falling-edge serclk).
// Ports: serclk, reset, in, frame -> o_word (post-shift value), o_done, o_short.
module shift_ser_core
    import shift_ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             serclk,
    input  logic             reset,
    input  logic             in,
    input  logic             frame,
    output logic [WIDTH-1:0] o_word,
    output logic             o_done,
    output logic             o_short
);

    localparam int             CW   = CNT_W(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] w_sh_next;
    logic [CW-1:0]    r_cnt;

    always_comb begin
        if (MSB_FIRST != LSB_FIRST) begin
            w_sh_next = {r_sh[WIDTH-2:0], in};
        end else begin
            w_sh_next = {in, r_sh[WIDTH-1:1]};
        end
    end

    // The completed word is the value the register takes on this edge.
    assign o_word  = w_sh_next;
    assign o_done  = frame && (r_cnt == LAST);
    assign o_short = !frame && (r_cnt != '0);

    always_ff @(negedge serclk or posedge reset) begin
        if (reset) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (frame) begin
            r_sh  <= w_sh_next;
            r_cnt <= o_done ? '0 : r_cnt + CW'(1);
        end else begin
            r_sh  <= '0;
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/shift_ser_in_framed.sv
// Framed serial-to-parallel receiver with valid/ready holding register.
// Ports: serclk, reset, in, frame, out_ready, clr_err -> out, out_valid, overrun, short_frame.
module shift_ser_in_framed
    import shift_ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             serclk,
    input  logic             reset,
    input  logic             in,
    input  logic             frame,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             overrun,
    output logic             short_frame
);

    logic [WIDTH-1:0] w_word;
    logic             w_done;
    logic             w_short;
    logic             w_load;
    logic             w_ovr_set;

    logic [WIDTH-1:0] r_out;
    logic             r_valid;
    logic             r_ovr;
    logic             r_short;

    shift_ser_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .serclk  (serclk),
        .reset   (reset),
        .in      (in),
        .frame   (frame),
        .o_word  (w_word),
        .o_done  (w_done),
        .o_short (w_short)
    );

    // Holding register is free if empty or being consumed this edge.
    assign w_load    = w_done && (!r_valid || out_ready);
    assign w_ovr_set = w_done && r_valid && !out_ready;

    always_ff @(negedge serclk or posedge reset) begin
        if (reset) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_short <= 1'b0;
        end else begin
            if (w_load) begin
                r_out   <= w_word;
                r_valid <= 1'b1;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            // Set events win over a simultaneous clear.
            r_ovr   <= w_ovr_set | (r_ovr & ~clr_err);
            r_short <= w_short | (r_short & ~clr_err);
        end
    end

    assign out         = r_out;
    assign out_valid   = r_valid;
    assign overrun     = r_ovr;
    assign short_frame = r_short;

endmodule

// File: tb/tb_shift_ser_in_framed.sv
// Bench for shift_ser_in_framed: MSB-first and LSB-first instances side by side.
// Directed scenarios then random traffic against a bit-list reference model.
module tb_shift_ser_in_framed;

    logic       serclk = 1'b0;
    logic       reset;
    logic       in_b;
    logic       frame;
    logic       out_ready;
    logic       clr_err;

    logic [7:0] out_m, out_l;
    logic       val_m, val_l, ov_m, ov_l, sf_m, sf_l;

    int checks   = 0;
    int failures = 0;

    // Model: index 0 = LSB-first instance, 1 = MSB-first instance.
    int         mcnt;
    bit         mbits[8];
    logic [7:0] mout[2];
    bit         mval[2];
    bit         mov[2];
    bit         msf[2];

    always #5 serclk = ~serclk;

    shift_ser_in_framed #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .serclk      (serclk),
        .reset       (reset),
        .in          (in_b),
        .frame       (frame),
        .out_ready   (out_ready),
        .clr_err     (clr_err),
        .out         (out_m),
        .out_valid   (val_m),
        .overrun     (ov_m),
        .short_frame (sf_m)
    );

    shift_ser_in_framed #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .serclk      (serclk),
        .reset       (reset),
        .in          (in_b),
        .frame       (frame),
        .out_ready   (out_ready),
        .clr_err     (clr_err),
        .out         (out_l),
        .out_valid   (val_l),
        .overrun     (ov_l),
        .short_frame (sf_l)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mcnt = 0;
        for (int k = 0; k < 2; k++) begin
            mout[k] = '0;
            mval[k] = 0;
            mov[k]  = 0;
            msf[k]  = 0;
        end
    endtask

    task automatic model_edge();
        logic [7:0] w[2];
        bit done;
        bit sset;
        bit oset[2];
        done    = 0;
        sset    = 0;
        oset[0] = 0;
        oset[1] = 0;
        w[0]    = '0;
        w[1]    = '0;
        if (frame) begin
            mbits[mcnt] = in_b;
            mcnt++;
            if (mcnt == 8) begin
                done = 1;
                for (int i = 0; i < 8; i++) begin
                    w[0] = w[0] | (8'(mbits[i]) << i);
                    w[1] = w[1] | (8'(mbits[i]) << (7 - i));
                end
                mcnt = 0;
            end
        end else begin
            if (mcnt != 0) sset = 1;
            mcnt = 0;
        end
        for (int k = 0; k < 2; k++) begin
            if (done) begin
                if (!mval[k] || out_ready) begin
                    mout[k] = w[k];
                    mval[k] = 1;
                end else begin
                    oset[k] = 1;
                end
            end else if (out_ready && mval[k]) begin
                mval[k] = 0;
            end
            mov[k] = oset[k] | (mov[k] & !clr_err);
            msf[k] = sset | (msf[k] & !clr_err);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, "_out_m"}, 32'(out_m), 32'(mout[1]));
        chk({tag, "_val_m"}, 32'(val_m), 32'(mval[1]));
        chk({tag, "_ov_m"},  32'(ov_m),  32'(mov[1]));
        chk({tag, "_sf_m"},  32'(sf_m),  32'(msf[1]));
        chk({tag, "_out_l"}, 32'(out_l), 32'(mout[0]));
        chk({tag, "_val_l"}, 32'(val_l), 32'(mval[0]));
        chk({tag, "_ov_l"},  32'(ov_l),  32'(mov[0]));
        chk({tag, "_sf_l"},  32'(sf_l),  32'(msf[0]));
    endtask

    task automatic step(bit b, bit f, bit r, bit c, string tag);
        in_b      = b;
        frame     = f;
        out_ready = r;
        clr_err   = c;
        @(negedge serclk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Sends w MSB-first on the wire; ready applies only on the last bit.
    task automatic send(logic [7:0] w, bit r_last, string tag);
        for (int i = 7; i >= 0; i--) begin
            step(w[i], 1'b1, (i == 0) ? r_last : 1'b0, 1'b0, tag);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_b      = 1'b0;
        frame     = 1'b0;
        out_ready = 1'b0;
        clr_err   = 1'b0;
        model_reset();
        #12;
        chk("rst_out_m", 32'(out_m), 32'h0);
        chk("rst_val_m", 32'(val_m), 32'h0);
        chk("rst_ov_m",  32'(ov_m),  32'h0);
        chk("rst_sf_l",  32'(sf_l),  32'h0);
        reset = 1'b0;

        // 1: async reset mid-word after a held word
        send(8'h5A, 1'b0, "t1w");
        chk("t1_pre_out", 32'(out_m), 32'h5A);
        step(1'b1, 1'b1, 1'b0, 1'b0, "t1a");
        step(1'b0, 1'b1, 1'b0, 1'b0, "t1b");
        step(1'b1, 1'b1, 1'b0, 1'b0, "t1c");
        #3 reset = 1'b1;
        #1;
        chk("t1_out_m", 32'(out_m), 32'h0);
        chk("t1_out_l", 32'(out_l), 32'h0);
        chk("t1_val_m", 32'(val_m), 32'h0);
        chk("t1_flags", 32'({ov_m, sf_m, ov_l, sf_l}), 32'h0);
        model_reset();
        reset = 1'b0;

        // 2: MSB-first A5, also checks restart at bit 0 after reset
        send(8'hA5, 1'b0, "t2");
        chk("t2_out_m", 32'(out_m), 32'hA5);
        chk("t2_val_m", 32'(val_m), 32'h1);

        // 3: LSB-first, bits 1,1,0,0,0,0,0,0
        step(1'b0, 1'b0, 1'b1, 1'b0, "t3c");
        send(8'hC0, 1'b0, "t3");
        chk("t3_out_l", 32'(out_l), 32'h03);
        chk("t3_val_l", 32'(val_l), 32'h1);

        // 4: back-to-back with overrun, then clear
        step(1'b0, 1'b0, 1'b1, 1'b0, "t4c");
        send(8'h3C, 1'b0, "t4a");
        send(8'hC3, 1'b0, "t4b");
        chk("t4_out_m", 32'(out_m), 32'h3C);
        chk("t4_ov_m",  32'(ov_m),  32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, "t4clr");
        chk("t4_ovclr", 32'(ov_m),  32'h0);

        // 5: ready on the 16th edge frees the register for the second word
        step(1'b0, 1'b0, 1'b1, 1'b0, "t5c");
        send(8'h3C, 1'b0, "t5a");
        send(8'hC3, 1'b1, "t5b");
        chk("t5_out_m", 32'(out_m), 32'hC3);
        chk("t5_val_m", 32'(val_m), 32'h1);
        chk("t5_ov_m",  32'(ov_m),  32'h0);

        // 6: short frame then clean word
        step(1'b0, 1'b0, 1'b1, 1'b0, "t6c");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "t6p");
        step(1'b0, 1'b0, 1'b0, 1'b0, "t6d");
        chk("t6_sf_m", 32'(sf_m), 32'h1);
        send(8'h81, 1'b0, "t6w");
        chk("t6_out_m", 32'(out_m), 32'h81);
        chk("t6_sf_hold", 32'(sf_m), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, "t6clr");
        chk("t6_sfclr", 32'(sf_m), 32'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) == 0),
                 "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
